// File: rtl/dpi_ctx_pkg.sv
// Shared types for the stream context manager: FSM states, default widths and
// a saturating increment used for both the global and per-stream hit counters.
package dpi_ctx_pkg;
  localparam int CTX_STATE_W = 11;
  localparam int CTX_SID_W   = 6;
  localparam int CTX_COUNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, COMMIT} ctx_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v,
                                          input logic        inc);
    return (inc && v != max_v) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/dpi_stream_ctx_mgr_if.sv
// Matcher-side bus: state load, delayed char stream, and matcher state/accept.
interface dpi_stream_ctx_mgr_if #(parameter int STATE_W = 11);
  logic [STATE_W-1:0] m_state_in;
  logic               m_state_in_vld;
  logic [7:0]         m_char_in;
  logic               m_char_in_vld;
  logic [STATE_W-1:0] m_state_out;
  logic               m_accept_out;

  modport master (output m_state_in, m_state_in_vld, m_char_in, m_char_in_vld,
                  input  m_state_out, m_accept_out);
  modport slave  (input  m_state_in, m_state_in_vld, m_char_in, m_char_in_vld,
                  output m_state_out, m_accept_out);
endinterface

// File: rtl/dpi_ctx_ram.sv
// 1W/1R context store with registered read and a resettable per-entry valid
// bit; an invalid entry reads as zero so the contents never need resetting.
module dpi_ctx_ram #(
  parameter int W     = 11,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          clr,
  input  logic [AW-1:0] caddr,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) valid <= '0;
    else begin
      if (clr) valid[caddr] <= 1'b0;
      if (we)  valid[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= valid[raddr] ? mem[raddr] : '0;
  end
endmodule

// File: rtl/dpi_stream_ctx_mgr.sv
// Per-stream save/restore of one regex matcher's state, sticky match flag and
// saturating global hit count. Optional per-stream stats: DPI_CTX_STREAM_STATS_EN.
module dpi_stream_ctx_mgr
  import dpi_ctx_pkg::*;
#(
  parameter int STATE_W     = CTX_STATE_W,
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = CTX_SID_W,
  parameter int COUNT_W     = CTX_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               new_stream_id,
  input  logic               flush_stream,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  dpi_stream_ctx_mgr_if.master mbus,
`ifdef DPI_CTX_STREAM_STATS_EN
  input  logic [SID_W-1:0]   stat_rd_id,
  output logic [COUNT_W-1:0] stat_rd_data,
`endif
  output logic               fired,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               abort
);
  ctx_state_e         state;
  logic [SID_W-1:0]   sid_q, pend_sid, rd_sid;
  logic               new_q, pend, pend_new, enable_q;
  logic               hit, flush_go, commit_we;
  logic [STATE_W-1:0] ctx_rd;

  // The RAM read is issued the cycle before LOAD: from IDLE (new or pending
  // load) or from RUN (abort reload), so the data is ready in LOAD.
  assign rd_sid    = (state == IDLE && pend) ? pend_sid : stream_id;
  assign flush_go  = (state == IDLE) && flush_stream && !load_state && !pend;
  assign commit_we = (state == COMMIT) && enable_q;
  assign hit       = fired | mbus.m_accept_out;
  assign busy      = (state != IDLE);

  assign mbus.m_state_in_vld = (state == LOAD);
  assign mbus.m_state_in     = (state == LOAD && !new_q) ? ctx_rd : '0;

  dpi_ctx_ram #(.W(STATE_W), .DEPTH(NUM_STREAMS), .AW(SID_W)) u_ctx (
    .clk(clk), .rst_n(rst_n),
    .we(commit_we), .waddr(sid_q), .wdata(mbus.m_state_out),
    .clr(flush_go), .caddr(stream_id),
    .raddr(rd_sid), .rdata(ctx_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mbus.m_char_in     <= '0;
      mbus.m_char_in_vld <= 1'b0;
    end else begin
      mbus.m_char_in     <= char_in;
      mbus.m_char_in_vld <= char_in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sid_q    <= '0;
      new_q    <= 1'b0;
      pend     <= 1'b0;
      pend_sid <= '0;
      pend_new <= 1'b0;
      enable_q <= 1'b0;
      fired    <= 1'b0;
      count    <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            state <= LOAD;
            sid_q <= pend_sid;
            new_q <= pend_new;
            pend  <= 1'b0;
            fired <= 1'b0;
          end else if (load_state) begin
            state <= LOAD;
            sid_q <= stream_id;
            new_q <= new_stream_id;
            fired <= 1'b0;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (mbus.m_accept_out) fired <= 1'b1;
          if (eop) begin
            state    <= COMMIT;
            enable_q <= enable;
            if (load_state) begin
              pend     <= 1'b1;
              pend_sid <= stream_id;
              pend_new <= new_stream_id;
            end
          end else if (load_state) begin
            // Abandon the packet: the old stream's context is never written.
            state <= LOAD;
            abort <= 1'b1;
            sid_q <= stream_id;
            new_q <= new_stream_id;
            fired <= 1'b0;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (enable_q) begin
            fired <= hit;
            count <= COUNT_W'(sat_inc(32'(count), 32'({COUNT_W{1'b1}}), hit));
          end else begin
            fired <= 1'b0;
          end
          if (load_state) begin
            pend     <= 1'b1;
            pend_sid <= stream_id;
            pend_new <= new_stream_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DPI_CTX_STREAM_STATS_EN
  logic               ld_go, stat_clr;
  logic [SID_W-1:0]   stat_caddr, stat_raddr;
  logic [COUNT_W-1:0] stat_rd, stat_cur;

  // Stats share their single read port with the host: a load steals it for
  // one cycle, so stat_rd_data is not meaningful in the LOAD cycle.
  assign ld_go      = (state == IDLE && (load_state || pend)) ||
                      (state == RUN && load_state && !eop);
  assign stat_raddr = ld_go ? rd_sid : stat_rd_id;
  assign stat_clr   = flush_go || (state == LOAD && new_q);
  assign stat_caddr = flush_go ? stream_id : sid_q;
  assign stat_rd_data = stat_rd;

  always_ff @(posedge clk) begin
    if (!rst_n)              stat_cur <= '0;
    else if (state == LOAD)  stat_cur <= new_q ? '0 : stat_rd;
  end

  dpi_ctx_ram #(.W(COUNT_W), .DEPTH(NUM_STREAMS), .AW(SID_W)) u_stats (
    .clk(clk), .rst_n(rst_n),
    .we(commit_we && hit), .waddr(sid_q),
    .wdata(COUNT_W'(sat_inc(32'(stat_cur), 32'({COUNT_W{1'b1}}), 1'b1))),
    .clr(stat_clr), .caddr(stat_caddr),
    .raddr(stat_raddr), .rdata(stat_rd)
  );
`endif
endmodule
